// File: rtl/alu_wb_buffer_pkg.sv
// Widths and constants shared by the ALU units, the writeback buffer and the register file.
package alu_wb_buffer_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned ZERO_REG   = 0;

endpackage

// File: rtl/alu_wb_fifo_mem.sv
// Entry storage and write/read pointers for the ALU writeback buffer.
module alu_wb_fifo_mem #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned PTR_W   = $clog2(DEPTH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic                           pop,
   input  logic [RADDR_W-1:0]             push_addr,
   input  logic [XLEN-1:0]                push_data,
   output logic [PTR_W-1:0]               rd_ptr,
   output logic [DEPTH-1:0][RADDR_W-1:0]  mem_addr,
   output logic [DEPTH-1:0][XLEN-1:0]     mem_data
);

   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mem_addr <= '0;
         mem_data <= '0;
      end else begin
         if (push) begin
            mem_addr[wr_ptr_q] <= push_addr;
            mem_data[wr_ptr_q] <= push_data;
            wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   assign rd_ptr = rd_ptr_q;

endmodule

// File: rtl/alu_wb_buffer.sv
// ALU result buffer feeding the register-file write port, with youngest-match forwarding.
module alu_wb_buffer #(
   parameter int unsigned XLEN    = alu_wb_buffer_pkg::XLEN,
   parameter int unsigned RADDR_W = alu_wb_buffer_pkg::REG_ADDR_W,
   parameter int unsigned DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_we,
   input  logic [RADDR_W-1:0] in_rd_addr,
   input  logic [XLEN-1:0]    in_result,
   output logic               rf_we,
   output logic [RADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]    rf_wdata,
   input  logic               rf_ready,
   input  logic [RADDR_W-1:0] fwd_raddr,
   output logic               fwd_hit,
   output logic [XLEN-1:0]    fwd_data
);

   import alu_wb_buffer_pkg::*;

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [CNT_W-1:0]                count_q, count_d;
   logic [PTR_W-1:0]                rd_ptr;
   logic [DEPTH-1:0][RADDR_W-1:0]   mem_addr;
   logic [DEPTH-1:0][XLEN-1:0]      mem_data;
   logic                            store, pop;

   assign in_ready = !rst && (count_q < CNT_W'(DEPTH));
   // Writes with no destination or to the zero register complete the handshake but are not kept.
   assign store    = in_valid && in_ready && in_we && (in_rd_addr != RADDR_W'(ZERO_REG));
   assign rf_we    = (count_q != '0);
   assign pop      = rf_we && rf_ready;
   assign rf_waddr = rf_we ? mem_addr[rd_ptr] : '0;
   assign rf_wdata = rf_we ? mem_data[rd_ptr] : '0;

   always_comb begin
      count_d = count_q;
      if (store && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!store && pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   alu_wb_fifo_mem #(
      .XLEN    (XLEN),
      .RADDR_W (RADDR_W),
      .DEPTH   (DEPTH),
      .PTR_W   (PTR_W)
   ) u_mem (
      .clk       (clk),
      .rst       (rst),
      .push      (store),
      .pop       (pop),
      .push_addr (in_rd_addr),
      .push_data (in_result),
      .rd_ptr    (rd_ptr),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data)
   );

   // Scan oldest to youngest so the last (youngest) match overrides earlier ones.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx      = '0;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (fwd_raddr != RADDR_W'(ZERO_REG)) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (mem_addr[idx] == fwd_raddr)) begin
               fwd_hit  = 1'b1;
               fwd_data = mem_data[idx];
            end
         end
      end
   end

endmodule

// File: doc/alu_wb_buffer.md
# alu_wb_buffer

Result buffer between the ALU (shifter, adder and logic units) and the register-file write port. Accepts one ALU result per cycle under a valid/ready handshake, holds up to DEPTH results in FIFO order, and drains them to the register file whenever its write port is free. Also exposes a combinational forwarding lookup so the operand-read stage can bypass results not yet written.

## Interface
Parameters:
- XLEN, 32, datapath width (result and forwarded data).
- RADDR_W, 5, register address width.
- DEPTH, 2, buffer entries; power of two, ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  ALU result presented.
- in_ready  out  1  buffer can accept this cycle.
- in_we  in  1  result is to be written (0 = no destination).
- in_rd_addr  in  RADDR_W  destination register.
- in_result  in  XLEN  ALU result (rd).
- rf_we  out  1  head entry valid; write request.
- rf_waddr  out  RADDR_W  head destination.
- rf_wdata  out  XLEN  head data.
- rf_ready  in  1  register file accepts the write this cycle.
- fwd_raddr  in  RADDR_W  operand address being read.
- fwd_hit  out  1  buffered entry matches fwd_raddr.
- fwd_data  out  XLEN  data of the youngest matching entry.

## Operation
- Push: in_valid && in_ready. Drop: in_we==0 or in_rd_addr==0. A dropped push completes the handshake but stores nothing and leaves count unchanged.
- Pop: rf_we && rf_ready. Head pointer advances; count decrements.
- in_ready = !rst && (count < DEPTH). Depends only on registered state; no combinational path from rf_ready.
- Simultaneous push and pop:
  - Allowed when count < DEPTH; count unchanged, pointers both advance.
  - When full, in_ready=0, so no push that cycle.
- Order preserved: writes reach the register file in acceptance order, including repeated writes to the same address.
- Forwarding:
  - Searches all valid entries; youngest match wins.
  - fwd_raddr==0 never hits. fwd_hit=0 gives fwd_data=0.
  - The incoming in_result (not yet stored) is not searched.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- No states beyond pointers and count; occupancy EMPTY / PARTIAL / FULL is derived from count.

## Timing
- Reset (async assert, sync release) gives:
  - count=0, pointers=0, storage cleared.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - fwd_hit=0, fwd_data=0, in_ready=0.
  - in_ready=1 from the first cycle after rst falls.
- Latency: a result pushed at edge N drives rf_we/rf_waddr/rf_wdata from N until popped. It is visible to forwarding in the same cycle.
- Throughput: one result/cycle sustained while rf_ready=1.
- rf_ready=0 stalls the head. rf_we and rf_waddr/rf_wdata stay stable until the pop.
- Reset mid-operation discards all buffered entries; none are written.

## Structure
- Shared include file: XLEN, REG_ADDR_W, ZERO_REG (0). Shared with ALU units and register file.
- One sub-module: alu_wb_fifo_mem, holding storage plus the write/read pointers. The forwarding priority search and handshake logic stay in alu_wb_buffer.

## Test plan
- Reset, then push {we=1, addr=3, result=1} with rf_ready=1. Required: rf_we=1, waddr=3, wdata=1 the next cycle; pop, then empty.
- Hold rf_ready=0 and push two results (addr 5 = 0x40000000, addr 6 = 0x1). Required: in_ready=0 after the second push, the third push is blocked, and the head stays at addr 5. Release rf_ready: writes drain in order 5, then 6.
- Push addr 0 and push we=0. Required: both handshakes complete, rf_we stays 0, and count stays 0.
- Push addr 7 = 0xA, then addr 7 = 0xB, with rf_ready=0 and fwd_raddr=7. Required: fwd_hit=1, fwd_data=0xB. Also fwd_raddr=0 gives fwd_hit=0.
- Push every cycle with rf_ready=1 for 8 cycles. Required: in_ready stays 1, 8 writes emerge in order, and the pointers wrap cleanly.
- Assert rst with the buffer full. Required: rf_we=0 immediately (asynchronously), and after release no stale write appears.
